neighbor_classifier: RTL and testbench
======================================

NEIGHBOR_CLASSIFIER -- requirements
Module: neighbor_classifier

Interface
REQ-001 The block SHALL have parameter NUM_NEIGHBORS, default 8: neighbour bits per cell, legal range 1..15.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 CLK  input  1: sole clock; all state SHALL update on its rising edge.
REQ-004 RST_N  input  1: asynchronous active-low reset.
REQ-005 START  input  1: single-cycle request to begin classifying one cell.
REQ-006 BIT_VALID  input  1: BIT_IN carries a valid neighbour bit.
REQ-007 BIT_IN  input  1: neighbour liveness, 1 = alive.
REQ-008 BIT_READY  output  1: block accepts a neighbour bit this cycle.
REQ-009 CLASS_OUT  output  2: classification code, driving the downstream 2-to-4 decoder VAL_IN.
REQ-010 CLASS_VALID  output  1: CLASS_OUT holds a final result.
REQ-011 CLASS_READY  input  1: consumer takes the result.
REQ-012 BUSY  output  1: high in ACCUM or DONE.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, ACCUM, DONE.
REQ-014 In IDLE, START=1 SHALL clear the 4-bit live count and beat index and enter ACCUM next cycle.
REQ-015 BIT_READY SHALL be 1 only in ACCUM; a beat is accepted when BIT_VALID and BIT_READY are both 1.
REQ-016 Each accepted beat SHALL add BIT_IN to the count and increment the index; idle cycles (BIT_VALID=0) SHALL change nothing.
REQ-017 The beat that brings the index to NUM_NEIGHBORS SHALL move the FSM to DONE on the following edge, with CLASS_OUT registered from the final count.
REQ-018 The classification SHALL be: count 0-1 -> 2'b00; count 2 -> 2'b01; count 3 -> 2'b10; count >=4 -> 2'b11.
REQ-019 In DONE, CLASS_VALID SHALL be 1, and CLASS_OUT SHALL remain stable until the cycle in which CLASS_READY=1.
REQ-020 In DONE with CLASS_READY=1, the FSM SHALL go to IDLE, or to ACCUM with the count cleared if START=1 in the same cycle.
REQ-021 START SHALL be ignored in ACCUM and in DONE unless CLASS_READY=1.
REQ-022 Minimum latency SHALL be NUM_NEIGHBORS+1 cycles from START to CLASS_VALID when BIT_VALID is held high.
REQ-023 The count SHALL NOT wrap; 4 bits covers the maximum NUM_NEIGHBORS.
REQ-024 CLASS_VALID and BIT_READY SHALL never both be 1.

Reset
REQ-025 Asserting RST_N=0 at any time, including mid-ACCUM or in DONE, SHALL immediately force: state IDLE, count 0, index 0, CLASS_OUT=2'b00, CLASS_VALID=0, BIT_READY=0, BUSY=0.
REQ-026 After RST_N deasserts, the block SHALL act on START only from the first rising edge at which RST_N is high.

Configuration
REQ-027 Macro NEIGHBOR_EARLY_EXIT_EN SHALL control early termination.
- Defined: the accepted beat that brings the count to 4 SHALL move the FSM to DONE with CLASS_OUT=2'b11. Remaining bits for that cell are not consumed; the upstream SHALL drop them.
- Undefined: all NUM_NEIGHBORS beats SHALL always be consumed.

Verification
REQ-028 Reset, then START with bits 1,0,0,0,0,0,0,0 and BIT_VALID held high -> CLASS_VALID in cycle 9 after START with CLASS_OUT=2'b00.
REQ-029 Bits 1,1,0,0,0,0,0,0, then 1,1,1,0,0,0,0,0, each followed by CLASS_READY -> CLASS_OUT 2'b01 then 2'b10; CLASS_OUT is held while CLASS_READY=0 for 5 cycles.
REQ-030 All-ones bits -> CLASS_OUT=2'b11 in cycle 9 without the macro; with NEIGHBOR_EARLY_EXIT_EN, CLASS_OUT=2'b11 in cycle 5 and BIT_READY=0 from then on.
REQ-031 BIT_VALID toggled 1,0,1,0,... with bits totalling 2 -> result only after 8 accepted beats, CLASS_OUT=2'b01; START during ACCUM has no effect.
REQ-032 RST_N=0 after 4 accepted beats -> all outputs at reset values that same cycle; a following START with bits totalling 3 -> CLASS_OUT=2'b10.
REQ-033 CLASS_READY=1 and START=1 together in DONE -> BIT_READY=1 on the next cycle with a fresh count; no IDLE cycle in between.

Source files
------------

// File: rtl/neighbor_classifier_if.sv
// -----------------------------------------------------------------------------
// neighbor_classifier_if
//   Handshake bundle between a neighbour-bit producer / result consumer and the
//   neighbor_classifier block. Member names carry the direction as seen from
//   the classifier (i_ = into the block, o_ = out of the block).
//
//   Members:
//     i_start       request to begin classifying one cell (single cycle)
//     i_bit_valid   i_bit_in carries a valid neighbour bit
//     i_bit_in      neighbour liveness, 1 = alive
//     o_bit_ready   block accepts a neighbour bit this cycle
//     o_class_out   2-bit classification code
//     o_class_valid o_class_out holds a final result
//     i_class_ready consumer takes the result
//     o_busy        block is accumulating or holding a result
//
//   Modports:
//     master  producer / consumer side (drives the i_ members)
//     slave   classifier side (drives the o_ members)
// -----------------------------------------------------------------------------
interface neighbor_classifier_if;

  logic       i_start;
  logic       i_bit_valid;
  logic       i_bit_in;
  logic       o_bit_ready;
  logic [1:0] o_class_out;
  logic       o_class_valid;
  logic       i_class_ready;
  logic       o_busy;

  modport master (
    output i_start,
    output i_bit_valid,
    output i_bit_in,
    output i_class_ready,
    input  o_bit_ready,
    input  o_class_out,
    input  o_class_valid,
    input  o_busy
  );

  modport slave (
    input  i_start,
    input  i_bit_valid,
    input  i_bit_in,
    input  i_class_ready,
    output o_bit_ready,
    output o_class_out,
    output o_class_valid,
    output o_busy
  );

endinterface : neighbor_classifier_if

// File: rtl/neighbor_classifier.sv
// -----------------------------------------------------------------------------
// neighbor_classifier
//   Counts the live neighbours of one cell, delivered serially as single-bit
//   beats on a valid/ready handshake, and reports a 2-bit class code:
//     0-1 live -> 2'b00, 2 live -> 2'b01, 3 live -> 2'b10, 4+ live -> 2'b11.
//   The code drives a downstream 2-to-4 decoder.
//
//   States: IDLE (wait for start), ACCUM (take NUM_NEIGHBORS beats),
//   DONE (hold result until the consumer takes it). A start presented in the
//   same cycle the result is taken chains straight into the next ACCUM.
//
//   Parameters:
//     NUM_NEIGHBORS  neighbour bits per cell, legal range 1..15
//
//   Ports:
//     i_clk    sole clock, rising edge
//     i_rst_n  asynchronous active-low reset
//     bus      neighbor_classifier_if.slave handshake bundle
//
//   Build option:
//     NEIGHBOR_EARLY_EXIT_EN  when defined, the beat that brings the live count
//                             to 4 finishes the cell immediately with 2'b11;
//                             the producer drops the remaining bits itself.
//                             When undefined, every cell consumes all beats.
// -----------------------------------------------------------------------------
module neighbor_classifier #(
  parameter int NUM_NEIGHBORS = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  neighbor_classifier_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Beat index value that marks the final neighbour of a cell.
  localparam logic [3:0] LP_LAST_INDEX = 4'(NUM_NEIGHBORS);

  // Live-count to class-code mapping.
  function automatic logic [1:0] classify(input logic [3:0] count);
    logic [1:0] code;
    case (count)
      4'd0, 4'd1: code = 2'b00;
      4'd2:       code = 2'b01;
      4'd3:       code = 2'b10;
      default:    code = 2'b11;
    endcase
    return code;
  endfunction

  state_t     r_state;
  logic [3:0] r_count;
  logic [3:0] r_index;
  logic [1:0] r_class_out;
  logic       r_class_valid;
  logic       r_bit_ready;
  logic       r_busy;

  logic       w_accept;
  logic [3:0] w_count_next;
  logic [3:0] w_index_next;
  logic       w_last_beat;
  logic       w_early_exit;
  logic       w_finish;

  // r_bit_ready is high exactly while in ACCUM, so it doubles as the state
  // qualifier for beat acceptance.
  assign w_accept     = r_bit_ready & bus.i_bit_valid;
  // Count cannot exceed NUM_NEIGHBORS (<= 15), so the 4-bit add never wraps.
  assign w_count_next = r_count + {3'b000, bus.i_bit_in};
  assign w_index_next = r_index + 4'd1;
  assign w_last_beat  = (w_index_next == LP_LAST_INDEX);

`ifdef NEIGHBOR_EARLY_EXIT_EN
  assign w_early_exit = (w_count_next == 4'd4);
`else
  assign w_early_exit = 1'b0;
`endif

  assign w_finish = w_last_beat | w_early_exit;

  // Classifier FSM with registered handshake outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_count       <= 4'd0;
      r_index       <= 4'd0;
      r_class_out   <= 2'b00;
      r_class_valid <= 1'b0;
      r_bit_ready   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_start) begin
            r_state     <= ST_ACCUM;
            r_count     <= 4'd0;
            r_index     <= 4'd0;
            r_bit_ready <= 1'b1;
            r_busy      <= 1'b1;
          end else begin
            r_state     <= ST_IDLE;
            r_bit_ready <= 1'b0;
            r_busy      <= 1'b0;
          end
          r_class_valid <= 1'b0;
        end

        ST_ACCUM: begin
          // start is deliberately not looked at here.
          if (w_accept) begin
            r_count <= w_count_next;
            r_index <= w_index_next;
            if (w_finish) begin
              r_state       <= ST_DONE;
              // Early exit only fires at exactly four, which classifies as
              // 2'b11 anyway, so one mapping covers both paths.
              r_class_out   <= classify(w_count_next);
              r_class_valid <= 1'b1;
              r_bit_ready   <= 1'b0;
            end else begin
              r_state <= ST_ACCUM;
            end
          end else begin
            r_state <= ST_ACCUM;
          end
        end

        ST_DONE: begin
          // Result (and class code) is frozen until the consumer takes it.
          if (bus.i_class_ready) begin
            r_class_valid <= 1'b0;
            if (bus.i_start) begin
              // Chain directly into the next cell without an IDLE bubble.
              r_state     <= ST_ACCUM;
              r_count     <= 4'd0;
              r_index     <= 4'd0;
              r_bit_ready <= 1'b1;
              r_busy      <= 1'b1;
            end else begin
              r_state     <= ST_IDLE;
              r_bit_ready <= 1'b0;
              r_busy      <= 1'b0;
            end
          end else begin
            r_state       <= ST_DONE;
            r_class_valid <= 1'b1;
          end
        end

        default: begin
          // Unreachable encoding: recover to a clean idle state.
          r_state       <= ST_IDLE;
          r_count       <= 4'd0;
          r_index       <= 4'd0;
          r_class_out   <= 2'b00;
          r_class_valid <= 1'b0;
          r_bit_ready   <= 1'b0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_bit_ready   = r_bit_ready;
  assign bus.o_class_out   = r_class_out;
  assign bus.o_class_valid = r_class_valid;
  assign bus.o_busy        = r_busy;

endmodule : neighbor_classifier

// File: tb/tb_neighbor_classifier.sv
// -----------------------------------------------------------------------------
// tb_neighbor_classifier
//   Directed bench for neighbor_classifier (NUM_NEIGHBORS = 8). Expected class
//   codes, cycle latencies and accepted-beat counts are computed by a small
//   model when a cell is driven, queued, and compared when the result appears.
// -----------------------------------------------------------------------------
module tb_neighbor_classifier;

  logic clk;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  logic [1:0] sb_class[$];
  int         sb_lat[$];
  int         sb_beats[$];
  logic [1:0] exp_last;

  neighbor_classifier_if bus_if ();

  neighbor_classifier #(.NUM_NEIGHBORS(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: class code from the number of ones in the cell.
  function automatic logic [1:0] model_class(input logic [7:0] bits);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 8; i++) cnt += int'(bits[i]);
    if (cnt <= 1)      return 2'b00;
    else if (cnt == 2) return 2'b01;
    else if (cnt == 3) return 2'b10;
    else               return 2'b11;
  endfunction

  // Model: beats consumed before the cell finishes.
  function automatic int model_beats(input logic [7:0] bits);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cnt += int'(bits[i]);
`ifdef NEIGHBOR_EARLY_EXIT_EN
      if (cnt == 4) return i + 1;
`endif
    end
    return 8;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    bus_if.i_start = 1'b1;
    tick();
    bus_if.i_start = 1'b0;
  endtask

  // Called in cycle 1 of ACCUM. Feeds bits (bit 0 first) until a result shows.
  task automatic run_accum(input string tag, input logic [7:0] bits,
                           input bit toggle, input bit poke_start);
    int cyc;
    int k;
    logic [1:0] ec;
    int el;
    int eb;
    cyc = 1;
    k   = 0;
    sb_class.push_back(model_class(bits));
    sb_beats.push_back(model_beats(bits));
    sb_lat.push_back(toggle ? 2 * model_beats(bits) : model_beats(bits) + 1);
    while (bus_if.o_class_valid !== 1'b1 && cyc < 64) begin
      bus_if.i_bit_valid = toggle ? (cyc % 2 == 1) : 1'b1;
      bus_if.i_bit_in    = (k < 8) ? bits[k] : 1'b0;
      bus_if.i_start     = poke_start && (cyc == 3);
      if (bus_if.i_bit_valid && bus_if.o_bit_ready === 1'b1) k++;
      tick();
      cyc++;
    end
    bus_if.i_bit_valid = 1'b0;
    bus_if.i_bit_in    = 1'b0;
    bus_if.i_start     = 1'b0;
    check({tag, "_valid"}, 32'(bus_if.o_class_valid), 32'd1);
    ec = sb_class.pop_front();
    el = sb_lat.pop_front();
    eb = sb_beats.pop_front();
    exp_last = ec;
    check({tag, "_class"},   32'(bus_if.o_class_out), 32'(ec));
    check({tag, "_latency"}, 32'(cyc), 32'(el));
    check({tag, "_beats"},   32'(k), 32'(eb));
    check({tag, "_rdy_lo"},  32'(bus_if.o_bit_ready), 32'd0);
    check({tag, "_busy"},    32'(bus_if.o_busy), 32'd1);
  endtask

  // Called in DONE. Holds for some cycles, then hands the result off.
  task automatic finish(input string tag, input int hold, input bit restart);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, 32'(bus_if.o_class_valid), 32'd1);
      check({tag, "_hold_class"}, 32'(bus_if.o_class_out), 32'(exp_last));
      check({tag, "_hold_rdy"},   32'(bus_if.o_bit_ready), 32'd0);
    end
    bus_if.i_class_ready = 1'b1;
    bus_if.i_start       = restart;
    tick();
    bus_if.i_class_ready = 1'b0;
    bus_if.i_start       = 1'b0;
    check({tag, "_taken_valid"}, 32'(bus_if.o_class_valid), 32'd0);
    check({tag, "_taken_rdy"},   32'(bus_if.o_bit_ready), 32'(restart));
    check({tag, "_taken_busy"},  32'(bus_if.o_busy), 32'(restart));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_class"}, 32'(bus_if.o_class_out), 32'd0);
    check({tag, "_valid"}, 32'(bus_if.o_class_valid), 32'd0);
    check({tag, "_rdy"},   32'(bus_if.o_bit_ready), 32'd0);
    check({tag, "_busy"},  32'(bus_if.o_busy), 32'd0);
  endtask

  initial begin
    rst_n                = 1'b0;
    bus_if.i_start       = 1'b0;
    bus_if.i_bit_valid   = 1'b0;
    bus_if.i_bit_in      = 1'b0;
    bus_if.i_class_ready = 1'b0;
    exp_last             = 2'b00;

    // Power-on reset.
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_busy", 32'(bus_if.o_busy), 32'd0);

    // One live neighbour -> 00, result in cycle 9.
    start_pulse();
    check("accum_rdy", 32'(bus_if.o_bit_ready), 32'd1);
    run_accum("one", 8'b0000_0001, 1'b0, 1'b0);
    finish("one", 0, 1'b0);

    // Two then three live neighbours, each held 5 cycles before hand-off.
    start_pulse();
    run_accum("two", 8'b0000_0011, 1'b0, 1'b0);
    finish("two", 5, 1'b0);
    start_pulse();
    run_accum("three", 8'b0000_0111, 1'b0, 1'b0);
    finish("three", 5, 1'b0);

    // All ones -> 11 (cycle 5 with early exit, cycle 9 without).
    start_pulse();
    run_accum("ones", 8'b1111_1111, 1'b0, 1'b0);
    finish("ones", 2, 1'b0);

    // Gapped valid with a stray start mid-cell; two live -> 01 after 8 beats.
    start_pulse();
    run_accum("gap", 8'b0001_0010, 1'b1, 1'b1);
    finish("gap", 0, 1'b0);

    // Take result and start together: straight back into ACCUM.
    start_pulse();
    run_accum("b2b_a", 8'b0000_1111, 1'b0, 1'b0);
    finish("b2b_a", 0, 1'b1);
    run_accum("b2b_b", 8'b1010_0000, 1'b0, 1'b0);
    finish("b2b_b", 0, 1'b0);

    // Reset after four accepted beats.
    start_pulse();
    bus_if.i_bit_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_if.i_bit_in = (i % 2 == 0);
      tick();
    end
    check("mid_rdy_before", 32'(bus_if.o_bit_ready), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    bus_if.i_bit_valid = 1'b0;
    bus_if.i_bit_in    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", 32'(bus_if.o_busy), 32'd0);
    start_pulse();
    run_accum("after_rst", 8'b0100_1001, 1'b0, 1'b0);
    finish("after_rst", 0, 1'b0);

    // Reset while holding a nonzero result in DONE.
    start_pulse();
    run_accum("done_rst", 8'b1111_0000, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("done_rst_rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("done_rst_idle", 32'(bus_if.o_busy), 32'd0);

    check("sb_empty", 32'(sb_class.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_neighbor_classifier
